mem_wb_skid_reg: RTL and testbench

//  Parametrised MEM->WB pipeline stage register with valid/ready handshake and a 2-entry skid buffer.

---
 rtl/mem_wb_skid_reg.sv | 143 ++++++++++++++
 tb/tb_mem_wb_skid_reg.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_skid_reg.sv
// MEM->WB stage register: valid/ready handshake with a 2-entry skid buffer.
// MAIN drives the WB outputs and SKID holds the newer entry under back-pressure.
// Also provides a forwarding lookup over both held entries and a saturating stall counter.
module mem_wb_skid_reg #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,      // active-low, asynchronous
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_wr_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_wr_en,
    input  logic [RD_W-1:0]   q_rs,
    output logic              q_hit,
    output logic [DATA_W-1:0] q_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic [RD_W-1:0]     main_rd_q, main_rd_d, skid_rd_q, skid_rd_d;
    logic                main_we_q, main_we_d, skid_we_q, skid_we_d;
    logic                in_ready_q, in_ready_d;
    logic [CNT_W-1:0]    stall_q, stall_d;
    logic                accept, emit, main_vld, skid_vld;

    assign main_vld = (state_q != S_EMPTY);
    assign skid_vld = (state_q == S_FULL);
    assign accept   = in_valid & in_ready_q;
    assign emit     = main_vld & out_ready;

    // Next-state and payload movement between the input, SKID and MAIN
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_rd_d   = main_rd_q;
        main_we_d   = main_we_q;
        skid_data_d = skid_data_q;
        skid_rd_d   = skid_rd_q;
        skid_we_d   = skid_we_q;
        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    state_d     = S_ONE;
                    main_data_d = in_data;
                    main_rd_d   = in_rd;
                    main_we_d   = in_wr_en;
                end
            end
            S_ONE: begin
                if (accept && !emit) begin
                    state_d     = S_FULL;
                    skid_data_d = in_data;
                    skid_rd_d   = in_rd;
                    skid_we_d   = in_wr_en;
                end else if (accept && emit) begin
                    main_data_d = in_data;
                    main_rd_d   = in_rd;
                    main_we_d   = in_wr_en;
                end else if (emit) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                // in_ready is low here, so only a drain can happen
                if (emit) begin
                    state_d     = S_ONE;
                    main_data_d = skid_data_q;
                    main_rd_d   = skid_rd_q;
                    main_we_d   = skid_we_q;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        // Flush overrides everything; any payload loaded this cycle becomes invisible
        if (flush) state_d = S_EMPTY;
        in_ready_d = (state_d != S_FULL);
    end

    // Saturating count of cycles where WB back-pressures a valid entry
    always_comb begin
        stall_d = stall_q;
        if (main_vld && !out_ready && (stall_q != {CNT_W{1'b1}}))
            stall_d = stall_q + CNT_W'(1);
    end

    // State, payload, ready and counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_EMPTY;
            main_data_q <= '0;
            main_rd_q   <= '0;
            main_we_q   <= 1'b0;
            skid_data_q <= '0;
            skid_rd_q   <= '0;
            skid_we_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_rd_q   <= main_rd_d;
            main_we_q   <= main_we_d;
            skid_data_q <= skid_data_d;
            skid_rd_q   <= skid_rd_d;
            skid_we_q   <= skid_we_d;
            in_ready_q  <= in_ready_d;
            stall_q     <= stall_d;
        end
    end

    // Forwarding lookup: the younger SKID entry takes priority over MAIN
    always_comb begin
        q_hit  = 1'b0;
        q_data = '0;
        if (skid_vld && skid_we_q && (skid_rd_q == q_rs)) begin
            q_hit  = 1'b1;
            q_data = skid_data_q;
        end else if (main_vld && main_we_q && (main_rd_q == q_rs)) begin
            q_hit  = 1'b1;
            q_data = main_data_q;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_vld;
    assign out_data  = main_vld ? main_data_q : '0;
    assign out_rd    = main_vld ? main_rd_q : '0;
    assign out_wr_en = main_vld & main_we_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Bench for mem_wb_skid_reg: a queue of held entries is the scoreboard; entries are
// pushed when the bench sees an accept and popped when the stage emits.
module tb_mem_wb_skid_reg;
    localparam int DW = 32;
    localparam int RW = 4;
    localparam int CW = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [RW-1:0] in_rd = '0;
    logic          in_wr_en = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [RW-1:0] out_rd;
    logic          out_wr_en;
    logic [RW-1:0] q_rs = '0;
    logic          q_hit;
    logic [DW-1:0] q_data;
    logic [CW-1:0] stall_cnt;

    mem_wb_skid_reg #(.DATA_W(DW), .RD_W(RW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_rd(in_rd), .in_wr_en(in_wr_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd), .out_wr_en(out_wr_en),
        .q_rs(q_rs), .q_hit(q_hit), .q_data(q_data), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef logic [DW+RW:0] ent_t;   // {wr_en, rd, data}
    ent_t held[$];
    bit   m_rdy = 1'b0;
    int   m_cnt = 0;
    int   nchk = 0;
    int   nerr = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_data"}, 64'(out_data), 64'd0);
        chk({tag, "_out_rd"}, 64'(out_rd), 64'd0);
        chk({tag, "_out_wr_en"}, 64'(out_wr_en), 64'd0);
        chk({tag, "_q_hit"}, 64'(q_hit), 64'd0);
        chk({tag, "_q_data"}, 64'(q_data), 64'd0);
        chk({tag, "_stall_cnt"}, 64'(stall_cnt), 64'd0);
    endtask

    // One clock cycle: drive, compare every output with the scoreboard, then advance the model
    task automatic cyc(input bit v, input logic [DW-1:0] d, input logic [RW-1:0] r, input bit we,
                       input bit ordy, input bit fl, input logic [RW-1:0] qs, output bit acc);
        bit            hit;
        bit            emit;
        logic [DW-1:0] qd;
        @(negedge clk);
        in_valid = v; in_data = d; in_rd = r; in_wr_en = we;
        out_ready = ordy; flush = fl; q_rs = qs;
        #1;
        chk("in_ready", 64'(in_ready), 64'(m_rdy));
        chk("out_valid", 64'(out_valid), 64'(held.size() > 0));
        if (held.size() > 0) begin
            chk("out_data", 64'(out_data), 64'(held[0][DW-1:0]));
            chk("out_rd", 64'(out_rd), 64'(held[0][DW+:RW]));
            chk("out_wr_en", 64'(out_wr_en), 64'(held[0][DW+RW]));
        end else begin
            chk("out_wr_en_idle", 64'(out_wr_en), 64'd0);
        end
        hit = 1'b0;
        qd  = '0;
        for (int k = held.size() - 1; k >= 0; k--) begin
            if (!hit && held[k][DW+RW] && (held[k][DW+:RW] == qs)) begin
                hit = 1'b1;
                qd  = held[k][DW-1:0];
            end
        end
        chk("q_hit", 64'(q_hit), 64'(hit));
        chk("q_data", 64'(q_data), 64'(qd));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
        acc  = v & m_rdy & !fl;
        emit = (held.size() > 0) && ordy;
        @(posedge clk);
        if ((held.size() > 0) && !ordy && (m_cnt < CMAX)) m_cnt++;
        if (emit) void'(held.pop_front());
        if (fl) held.delete();
        else if (v && m_rdy) held.push_back({we, r, d});
        m_rdy = fl ? 1'b1 : (held.size() < 2);
    endtask

    task automatic idle(input bit ordy, input int n);
        bit a;
        for (int k = 0; k < n; k++) cyc(1'b0, '0, '0, 1'b0, ordy, 1'b0, '0, a);
    endtask

    initial begin
        bit a;
        int i;
        int guard;

        // Power-on reset
        #12;
        chk_zero("reset");
        @(negedge clk); #2 reset = 1'b1;
        @(posedge clk); m_rdy = 1'b1;

        // Stream four entries with WB always ready
        for (int k = 1; k <= 4; k++)
            cyc(1'b1, DW'(k * 'h11), RW'(k), 1'b1, 1'b1, 1'b0, RW'(k), a);
        idle(1'b1, 2);

        // Back-pressure: three offered, two held, release after a few cycles
        i = 0;
        for (int c = 0; c < 20 && i < 3; c++) begin
            cyc(1'b1, DW'((i + 1) * 'h11), RW'(i + 1), 1'b1, (c >= 5), 1'b0, RW'(2), a);
            if (a) i++;
        end
        chk("bp_all_accepted", 64'(i), 64'd3);
        idle(1'b1, 3);

        // Forwarding: both entries target rd 5, younger SKID wins
        cyc(1'b1, 'hA, 5, 1'b1, 1'b0, 1'b0, 5, a);
        cyc(1'b1, 'hB, 5, 1'b1, 1'b0, 1'b0, 5, a);
        cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 5, a);
        cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 6, a);
        idle(1'b1, 3);
        // SKID without wr_en: MAIN data is forwarded
        cyc(1'b1, 'hA, 5, 1'b1, 1'b0, 1'b0, 5, a);
        cyc(1'b1, 'hB, 5, 1'b0, 1'b0, 1'b0, 5, a);
        cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 5, a);
        idle(1'b1, 3);

        // Flush while FULL with a valid input: nothing survives
        cyc(1'b1, 'h55, 7, 1'b1, 1'b0, 1'b0, 7, a);
        cyc(1'b1, 'h66, 7, 1'b1, 1'b0, 1'b0, 7, a);
        cyc(1'b1, 'hDEAD, 7, 1'b1, 1'b0, 1'b1, 7, a);
        cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 7, a);
        idle(1'b1, 2);
        // Flush in ONE with an emit in the same cycle: the emit still completes
        cyc(1'b1, 'h77, 3, 1'b1, 1'b0, 1'b0, 3, a);
        cyc(1'b1, 'h88, 3, 1'b1, 1'b1, 1'b1, 3, a);
        idle(1'b1, 2);

        // Asynchronous reset pulse between edges while FULL
        cyc(1'b1, 'h91, 9, 1'b1, 1'b0, 1'b0, 9, a);
        cyc(1'b1, 'h92, 9, 1'b1, 1'b0, 1'b0, 9, a);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk_zero("async_reset");
        held.delete(); m_rdy = 1'b0; m_cnt = 0;
        #1 reset = 1'b1;
        @(posedge clk); m_rdy = 1'b1;
        idle(1'b0, 1);

        // Stall counter saturation with one entry held for ten cycles
        cyc(1'b1, 'hC3, 2, 1'b1, 1'b0, 1'b0, 2, a);
        idle(1'b0, 10);
        @(negedge clk); #1;
        chk("stall_sat", 64'(stall_cnt), 64'(CMAX));
        idle(1'b1, 2);

        // Random traffic
        guard = 0;
        for (int c = 0; c < 300; c++) begin
            cyc(($urandom_range(0, 3) != 0), DW'($urandom), RW'($urandom_range(0, 3)),
                $urandom_range(0, 1) == 1, ($urandom_range(0, 2) != 0),
                ($urandom_range(0, 29) == 0), RW'($urandom_range(0, 3)), a);
            if (a) guard++;
        end
        idle(1'b1, 3);
        chk("drained", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected to finish");
        $fatal(1, "timeout");
    end

endmodule
